fft_out_sched: RTL and testbench
================================

Name: fft_out_sched

Overview:
- Sequences one completed N-point FFT frame out of the FFT result RAM to the serial output device.
- Issues RAM reads in natural or bit-reversed order and registers each complex sample.
- Presents each sample over a 4-phase req/ans handshake, so the receiving device sets the output pace.
- Sits between the FFT core's result memory/done pulse and the output pins.

Parameters:
- N_LOG2, 4, log2 of FFT points per frame (N = 16).
- W, 16, width of each real/imag component.
- BIT_REV, 1, 1 = read RAM in bit-reversed address order; 0 = natural order.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse from the FFT core: frame ready in RAM.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last sample is acknowledged.
- rd_en  out  1  RAM read enable.
- rd_addr  out  N_LOG2  RAM read address.
- rd_dataR  in  W  RAM real data, valid one cycle after rd_en.
- rd_dataJ  in  W  RAM imag data, valid one cycle after rd_en.
- data_oR  out  W  registered real output sample.
- data_oJ  out  W  registered imag output sample.
- req_o  out  1  data valid request to the receiver.
- ans_i  in  1  receiver acknowledge; asynchronous to frame timing, synchronous to clk.
- word_idx  out  N_LOG2  natural-order index of the sample being presented.

Behaviour:
- Reset values: all outputs 0. State = IDLE; internal counter cnt = 0.
- Reset mid-frame aborts the frame immediately. No done pulse; data_o* are cleared.
- All outputs are registered.
- IDLE:
  - start=1 -> READ, cnt=0. Otherwise stay.
  - ans_i is ignored.
- READ (1 cycle):
  - rd_en=1.
  - rd_addr = BIT_REV ? bit-reverse(cnt) : cnt.
  - Next state: LOAD.
- LOAD (1 cycle):
  - data_oR/data_oJ <= rd_dataR/rd_dataJ; word_idx <= cnt.
  - Next state: REQ, with req_o=1 in that same cycle.
- REQ:
  - req_o=1; data_o* and word_idx held stable.
  - ans_i=1 sampled -> ACK, req_o deasserts in the next cycle.
- ACK:
  - req_o=0; wait for ans_i=0.
  - On ans_i=0: if cnt==N-1 -> DONE, else cnt+1 -> READ.
- DONE (1 cycle):
  - done=1, busy=0 in this cycle.
  - Next state: IDLE.
  - data_o* keep the last sample until the next LOAD.
- busy = 1 in READ, LOAD, REQ and ACK.
- start while busy or in DONE is ignored; it is not queued.
- Handshake rules:
  - ans_i already high when REQ is entered counts as the acknowledge in the first REQ cycle.
  - ACK always waits for ans_i low before the next read, so a stuck-high ans_i can never advance more than one sample.
- Minimum per-sample period is 4 cycles (READ, LOAD, REQ, ACK) with a receiver that acknowledges instantly.
- Minimum frame time is 4N + 1 cycles from the start pulse to the done pulse.
- Counter: N_LOG2 bits, no wrap past N-1; terminal check on cnt==N-1.
- No stall from the RAM side: the read data is always assumed valid exactly one cycle after rd_en.

Test Plan:
- Reset, then 10 idle cycles with ans_i toggling -> all outputs stay 0; busy=0; no rd_en.
- N=16, BIT_REV=1, RAM[k] = {k, ~k}, receiver acks one cycle after req_o and drops ack one cycle after req_o falls:
  - rd_addr sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - data_oR matches RAM[rd_addr] in each REQ.
  - word_idx runs 0..15.
  - done pulses exactly once.
- BIT_REV=0, receiver holds ans_i high permanently -> exactly one sample is transferred; FSM stays in ACK; busy=1; no second rd_en.
- Receiver holds off ack for 20 cycles on sample 5 -> req_o high for the whole 20 cycles; data_oR/data_oJ and word_idx=5 are stable throughout.
- start pulsed again at sample 3 and in the DONE cycle -> both ignored; exactly 16 samples are sent, then IDLE.
- rst asserted while in REQ on sample 7 -> req_o, busy and data_o* go to 0 asynchronously; no done pulse; a new start afterwards restarts from rd_addr 0.

Source files
------------

// File: rtl/fft_out_sched_if.sv
// Bus bundle between the FFT output scheduler, the FFT result RAM,
// the FFT core's start pulse and the serial output receiver.
interface fft_out_sched_if #(
   parameter int N_LOG2 = 4,
   parameter int W      = 16
);
   logic              start;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [N_LOG2-1:0] rd_addr;
   logic [W-1:0]      rd_dataR;
   logic [W-1:0]      rd_dataJ;
   logic [W-1:0]      data_oR;
   logic [W-1:0]      data_oJ;
   logic              req_o;
   logic              ans_i;
   logic [N_LOG2-1:0] word_idx;

   // Scheduler side
   modport master (
      input  start, rd_dataR, rd_dataJ, ans_i,
      output busy, done, rd_en, rd_addr, data_oR, data_oJ, req_o, word_idx
   );

   // Environment side (core, RAM and receiver)
   modport slave (
      output start, rd_dataR, rd_dataJ, ans_i,
      input  busy, done, rd_en, rd_addr, data_oR, data_oJ, req_o, word_idx
   );
endinterface

// File: rtl/fft_out_sched.sv
// FFT output scheduler: walks one finished frame out of the result RAM,
// in natural or bit-reversed address order, and hands each complex sample
// to the receiver over a 4-phase req/ans handshake. Every output is a
// register decoded from the next state, so outputs line up with the state.
module fft_out_sched #(
   parameter int N_LOG2  = 4,
   parameter int W       = 16,
   parameter bit BIT_REV = 1'b1
) (
   input  logic clk,
   input  logic rst,
   fft_out_sched_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_LOAD = 3'd2,
      S_REQ  = 3'd3,
      S_ACK  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};
   localparam logic [N_LOG2-1:0] CNT_ONE  = {{(N_LOG2-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [N_LOG2-1:0] cnt_q, cnt_d;
   logic              rd_en_q;
   logic [N_LOG2-1:0] rd_addr_q;
   logic [W-1:0]      data_r_q;
   logic [W-1:0]      data_j_q;
   logic [N_LOG2-1:0] word_idx_q;
   logic              req_q;
   logic              busy_q;
   logic              done_q;

   // Mirror the low N_LOG2 bits of an index (MSB becomes LSB).
   function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] v);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < N_LOG2; i++) begin
         r[i] = v[N_LOG2-1-i];
      end
      return r;
   endfunction

   // Next-state and sample-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_READ;
               cnt_d   = {N_LOG2{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: state_d = S_LOAD;
         S_LOAD: state_d = S_REQ;
         S_REQ: begin
            if (bus.ans_i) begin
               state_d = S_ACK;
            end else begin
               state_d = S_REQ;
            end
         end
         S_ACK: begin
            // A stuck-high ans_i keeps us here: never advance more than one sample.
            if (!bus.ans_i) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end else begin
               state_d = S_ACK;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= {N_LOG2{1'b0}};
         rd_en_q    <= 1'b0;
         rd_addr_q  <= {N_LOG2{1'b0}};
         data_r_q   <= {W{1'b0}};
         data_j_q   <= {W{1'b0}};
         word_idx_q <= {N_LOG2{1'b0}};
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_en_q <= (state_d == S_READ);
         if (state_d == S_READ) begin
            rd_addr_q <= BIT_REV ? bit_rev(cnt_d) : cnt_d;
         end
         // RAM data is valid during LOAD, one cycle after rd_en.
         if (state_q == S_LOAD) begin
            data_r_q   <= bus.rd_dataR;
            data_j_q   <= bus.rd_dataJ;
            word_idx_q <= cnt_q;
         end
         req_q  <= (state_d == S_REQ);
         busy_q <= (state_d == S_READ) || (state_d == S_LOAD) ||
                   (state_d == S_REQ)  || (state_d == S_ACK);
         done_q <= (state_d == S_DONE);
      end
   end

   assign bus.rd_en    = rd_en_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.data_oR  = data_r_q;
   assign bus.data_oJ  = data_j_q;
   assign bus.word_idx = word_idx_q;
   assign bus.req_o    = req_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_fft_out_sched.sv
// Self-checking bench for fft_out_sched: randomized RAM contents and
// receiver timing, checked against the expected read order, sample data
// and handshake behaviour of a 16-point frame.
`timescale 1ns/1ps
module tb_fft_out_sched;

   localparam int N_LOG2 = 4;
   localparam int N      = 16;
   localparam int W      = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fft_out_sched_if #(.N_LOG2(N_LOG2), .W(W)) ifr ();
   fft_out_sched_if #(.N_LOG2(N_LOG2), .W(W)) ifn ();

   fft_out_sched #(.N_LOG2(N_LOG2), .W(W), .BIT_REV(1'b1)) u_dut_rev (
      .clk (clk),
      .rst (rst),
      .bus (ifr.master)
   );

   fft_out_sched #(.N_LOG2(N_LOG2), .W(W), .BIT_REV(1'b0)) u_dut_nat (
      .clk (clk),
      .rst (rst),
      .bus (ifn.master)
   );

   // Reference: bit-reversed read order of a 16-point frame.
   int rev_tab [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   logic [W-1:0] ram_r [N];
   logic [W-1:0] ram_j [N];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int addr_q [$];
   int done_cnt   = 0;
   int rden_cnt   = 0;
   int rden_n_cnt = 0;

   // Result RAM model: data appears one cycle after rd_en.
   always @(posedge clk) begin
      if (ifr.rd_en) begin
         ifr.rd_dataR <= ram_r[ifr.rd_addr];
         ifr.rd_dataJ <= ram_j[ifr.rd_addr];
      end
      if (ifn.rd_en) begin
         ifn.rd_dataR <= ram_r[ifn.rd_addr];
         ifn.rd_dataJ <= ram_j[ifn.rd_addr];
      end
   end

   // Free-running cycle counter.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record read addresses, read strobes and done pulses.
   always @(negedge clk) begin
      if (ifr.rd_en) begin
         addr_q.push_back(int'(ifr.rd_addr));
         rden_cnt++;
      end
      if (ifr.done) done_cnt++;
      if (ifn.rd_en) rden_n_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill_ram(input bit fixed);
      for (int k = 0; k < N; k++) begin
         if (fixed) begin
            ram_r[k] = W'(k);
            ram_j[k] = ~W'(k);
         end else begin
            ram_r[k] = W'($urandom);
            ram_j[k] = W'($urandom);
         end
      end
   endtask

   // One frame on the bit-reversed instance with a software receiver.
   // fast: ack in the first REQ cycle and drop it in the first ACK cycle.
   task automatic run_frame(input bit fast, input int stall_k, input bit glitch, input int abort_k);
      int base, dbase, rbase, t0, guard;
      bit stable;
      base  = addr_q.size();
      dbase = done_cnt;
      rbase = rden_cnt;
      ifr.start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      ifr.start = 1'b0;
      check_val("busy_after_start", ifr.busy, 1);
      for (int k = 0; k < N; k++) begin
         guard = 0;
         while (!ifr.req_o && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (!ifr.req_o) begin
            check_val("req_timeout", ifr.req_o, 1);
            return;
         end
         if (addr_q.size() > base + k)
            check_val("rd_addr", addr_q[base + k], rev_tab[k]);
         else
            check_val("rd_addr_missing", addr_q.size(), base + k + 1);
         check_val("data_oR", ifr.data_oR, ram_r[rev_tab[k]]);
         check_val("data_oJ", ifr.data_oJ, ram_j[rev_tab[k]]);
         check_val("word_idx", ifr.word_idx, k);
         if (k == abort_k) begin
            #2 rst = 1'b1;
            #1;
            check_val("abort_req", ifr.req_o, 0);
            check_val("abort_busy", ifr.busy, 0);
            check_val("abort_data", {ifr.data_oR, ifr.data_oJ}, 0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (k == stall_k) begin
            stable = 1'b1;
            repeat (20) begin
               @(negedge clk);
               if (!ifr.req_o || ifr.data_oR !== ram_r[rev_tab[k]] ||
                   ifr.data_oJ !== ram_j[rev_tab[k]] || ifr.word_idx !== N_LOG2'(k))
                  stable = 1'b0;
            end
            check_val("stall_stable", stable, 1);
         end else if (glitch && k == 3) begin
            ifr.start = 1'b1;
            @(negedge clk);
            ifr.start = 1'b0;
         end else if (!fast) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         ifr.ans_i = 1'b1;
         guard = 0;
         do begin
            @(negedge clk);
            guard++;
         end while (ifr.req_o && guard < 100);
         if (ifr.req_o) begin
            check_val("req_fall_timeout", ifr.req_o, 0);
            ifr.ans_i = 1'b0;
            return;
         end
         if (!fast) repeat ($urandom_range(0, 2)) @(negedge clk);
         ifr.ans_i = 1'b0;
      end
      guard = 0;
      while (!ifr.done && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_val("done_seen", ifr.done, 1);
      check_val("busy_in_done", ifr.busy, 0);
      if (fast) check_val("frame_cycles", cyc - t0, 4 * N + 1);
      if (glitch) begin
         ifr.start = 1'b1;
         @(negedge clk);
         ifr.start = 1'b0;
      end
      repeat (6) @(negedge clk);
      check_val("done_count", done_cnt - dbase, 1);
      check_val("rd_en_count", rden_cnt - rbase, N);
      check_val("idle_busy", ifr.busy, 0);
   endtask

   initial begin
      int dsnap, nb;
      rst = 1'b1;
      ifr.start = 1'b0;
      ifr.ans_i = 1'b0;
      ifn.start = 1'b0;
      ifn.ans_i = 1'b0;
      fill_ram(1'b1);
      repeat (3) @(negedge clk);
      check_val("reset_outs", {ifr.busy, ifr.done, ifr.rd_en, ifr.rd_addr, ifr.data_oR,
                               ifr.data_oJ, ifr.req_o, ifr.word_idx}, 0);
      rst = 1'b0;

      // Idle with a toggling ans_i: nothing may move.
      for (int i = 0; i < 10; i++) begin
         ifr.ans_i = ~ifr.ans_i;
         @(negedge clk);
         check_val("idle_outs", {ifr.busy, ifr.done, ifr.rd_en, ifr.rd_addr, ifr.data_oR,
                                 ifr.data_oJ, ifr.req_o, ifr.word_idx}, 0);
      end
      ifr.ans_i = 1'b0;
      @(negedge clk);

      // Frame with RAM[k] = {k, ~k} and an instant receiver.
      run_frame(1'b1, -1, 1'b0, -1);

      // Random data, random ack timing, 20-cycle hold on sample 5, stray starts.
      fill_ram(1'b0);
      run_frame(1'b0, 5, 1'b1, -1);

      // Reset during REQ of sample 7, then a clean restart.
      fill_ram(1'b0);
      dsnap = done_cnt;
      run_frame(1'b0, -1, 1'b0, 7);
      repeat (5) @(negedge clk);
      check_val("abort_no_done", done_cnt - dsnap, 0);
      check_val("abort_idle_busy", ifr.busy, 0);
      run_frame(1'b1, -1, 1'b0, -1);

      // A few more random frames.
      for (int f = 0; f < 3; f++) begin
         fill_ram(1'b0);
         run_frame(1'b0, -1, 1'b0, -1);
      end

      // Natural-order instance with ans_i stuck high: one sample only.
      fill_ram(1'b0);
      nb = rden_n_cnt;
      ifn.ans_i = 1'b1;
      ifn.start = 1'b1;
      @(negedge clk);
      ifn.start = 1'b0;
      repeat (30) @(negedge clk);
      check_val("stuck_rd_en", rden_n_cnt - nb, 1);
      check_val("stuck_busy", ifn.busy, 1);
      check_val("stuck_req", ifn.req_o, 0);
      check_val("stuck_word_idx", ifn.word_idx, 0);
      check_val("stuck_data", {ifn.data_oR, ifn.data_oJ}, {ram_r[0], ram_j[0]});
      // Release once: exactly one more sample, at natural address 1.
      ifn.ans_i = 1'b0;
      @(negedge clk);
      ifn.ans_i = 1'b1;
      repeat (30) @(negedge clk);
      check_val("nat_rd_en", rden_n_cnt - nb, 2);
      check_val("nat_word_idx", ifn.word_idx, 1);
      check_val("nat_data", {ifn.data_oR, ifn.data_oJ}, {ram_r[1], ram_j[1]});
      check_val("nat_busy", ifn.busy, 1);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ifn.ans_i = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
